// File: rtl/forward_park_if.sv
// Start/done handshake and data bundle for the forward Park transform.
interface forward_park_if #(
   parameter int D_WIDTH = 32
);
   logic signed [D_WIDTH-1:0] alpha;
   logic signed [D_WIDTH-1:0] beta;
   logic signed [D_WIDTH-1:0] sin;
   logic signed [D_WIDTH-1:0] cos;
   logic                      start;
   logic signed [D_WIDTH-1:0] D;
   logic signed [D_WIDTH-1:0] Q;
   logic                      busy;
   logic                      done;

   modport master (output alpha, beta, sin, cos, start, input D, Q, busy, done);
   modport slave  (input alpha, beta, sin, cos, start, output D, Q, busy, done);
endinterface

// File: rtl/forward_park.sv
// Forward Park transform (alpha/beta -> d/q) using one shared signed multiplier
// over four cycles, then round-half-up and saturate into D/Q.
module forward_park #(
   parameter int D_WIDTH = 32,
   parameter int Q_BITS  = 10
) (
   input logic           clk,
   input logic           rst,
   forward_park_if.slave bus
);
   localparam int PW = 2 * D_WIDTH;
   localparam int AW = 2 * D_WIDTH + 2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   localparam logic signed [AW-1:0] RND     = {{(AW-Q_BITS){1'b0}}, 1'b1, {(Q_BITS-1){1'b0}}};
   localparam logic signed [AW-1:0] SAT_MAX = {{(AW-D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_MIN = {{(AW-D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};

   logic [1:0]                state;
   logic [1:0]                idx;
   logic signed [D_WIDTH-1:0] a_r, b_r, s_r, c_r;
   logic signed [AW-1:0]      acc_d, acc_q;
   logic signed [D_WIDTH-1:0] op_x, op_y;
   logic signed [PW-1:0]      prod;
   logic signed [AW-1:0]      prod_ext;

   function automatic logic signed [D_WIDTH-1:0] round_sat(input logic signed [AW-1:0] acc);
      logic signed [AW-1:0] r;
      r = (acc + RND) >>> Q_BITS;
      if (r > SAT_MAX)      return SAT_MAX[D_WIDTH-1:0];
      else if (r < SAT_MIN) return SAT_MIN[D_WIDTH-1:0];
      else                  return r[D_WIDTH-1:0];
   endfunction

   // idx 0: alpha*cos, 1: beta*sin, 2: alpha*sin, 3: beta*cos
   always_comb begin
      op_x     = idx[0] ? b_r : a_r;
      op_y     = (idx[0] ^ idx[1]) ? s_r : c_r;
      prod     = PW'(op_x) * PW'(op_y);
      prod_ext = {{2{prod[PW-1]}}, prod};
   end

   assign bus.busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         a_r    <= '0;
         b_r    <= '0;
         s_r    <= '0;
         c_r    <= '0;
         acc_d  <= '0;
         acc_q  <= '0;
         bus.D  <= '0;
         bus.Q  <= '0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_r   <= bus.alpha;
                  b_r   <= bus.beta;
                  s_r   <= bus.sin;
                  c_r   <= bus.cos;
                  acc_d <= '0;
                  acc_q <= '0;
                  idx   <= '0;
                  state <= MUL;
               end
            end
            MUL: begin
               case (idx)
                  2'd0, 2'd1: acc_d <= acc_d + prod_ext;
                  2'd2:       acc_q <= acc_q - prod_ext;
                  default:    acc_q <= acc_q + prod_ext;
               endcase
               idx <= idx + 2'd1;
               if (idx == 2'd3) state <= OUT;
            end
            OUT: begin
               bus.D    <= round_sat(acc_d);
               bus.Q    <= round_sat(acc_q);
               bus.done <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
